// File: rtl/gg_nal_pkg.sv
// Shared constants and types for the Annex-B NAL word packer.
package gg_nal_pkg;

    localparam int unsigned ZR_W = 2;

    localparam logic [7:0] ZERO_BYTE  = 8'h00;
    localparam logic [7:0] START_BYTE = 8'h01;
    localparam logic [7:0] EPB_BYTE   = 8'h03;

    // zero_run saturates here; two zeros are enough to arm EPB/start detection
    localparam logic [ZR_W-1:0] ZERO_RUN_MAX   = ZR_W'(3);
    localparam logic [ZR_W-1:0] ZERO_RUN_ARMED = ZR_W'(2);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/gg_nal_byte_filter.sv
// Per-byte emulation-prevention strip and start-code detect; purely combinational,
// the caller owns the zero_run / start_pend state.
module gg_nal_byte_filter
    import gg_nal_pkg::*;
#(
    parameter bit EPB_STRIP = 1'b1
) (
    input  logic [7:0]      i_byte,
    input  logic [ZR_W-1:0] i_zero_run,
    input  logic            i_start_pend,
    output logic            o_keep_c,
    output logic            o_flag_c,
    output logic            o_epb_inc_c,
    output logic [ZR_W-1:0] o_zero_run_c,
    output logic            o_start_pend_c
);

    logic w_armed;

    assign w_armed = (i_zero_run >= ZERO_RUN_ARMED);

    always_comb begin
        o_keep_c       = 1'b1;
        o_flag_c       = 1'b0;
        o_epb_inc_c    = 1'b0;
        o_zero_run_c   = i_zero_run;
        o_start_pend_c = i_start_pend;
        if (EPB_STRIP && w_armed && (i_byte == EPB_BYTE)) begin
            o_keep_c     = 1'b0;
            o_epb_inc_c  = 1'b1;
            o_zero_run_c = '0;
        end else begin
            // the 0x01 itself carries the old pending flag; the byte after it is the header
            o_flag_c       = i_start_pend;
            o_start_pend_c = w_armed && (i_byte == START_BYTE);
            if (i_byte == ZERO_BYTE) begin
                o_zero_run_c = (i_zero_run == ZERO_RUN_MAX) ? ZERO_RUN_MAX
                                                            : i_zero_run + ZR_W'(1);
            end else begin
                o_zero_run_c = '0;
            end
        end
    end

endmodule

// File: rtl/gg_nal_word_packer.sv
// Packs a raw Annex-B byte stream into WID-bit big-endian words with PAD_WID-bit
// lookahead and per-byte NAL-header flags, stripping emulation-prevention bytes.
module gg_nal_word_packer
    import gg_nal_pkg::*;
#(
    parameter int unsigned WID       = 128,
    parameter int unsigned PAD_WID   = 32,
    parameter bit          EPB_STRIP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [WID-1:0]     out_bits,
    output logic [PAD_WID-1:0] out_pad,
    output logic [WID/8-1:0]   out_nal_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [15:0]        epb_cnt
);

    localparam int unsigned BYTE_WID  = WID / 8;
    localparam int unsigned PAD_BYTES = PAD_WID / 8;
    localparam int unsigned D         = BYTE_WID + PAD_BYTES;
    localparam int unsigned CNT_W     = $clog2(D + 1);

    state_t              r_state;
    logic [D*8-1:0]      r_buf;
    logic [D-1:0]        r_flg;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_real_cnt;
    logic [ZR_W-1:0]     r_zero_run;
    logic                r_start_pend;
    logic                r_flush_pend;
    logic                r_padded;
    logic [15:0]         r_epb_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;

    state_t              w_nxt_state;
    logic [D*8-1:0]      w_nxt_buf;
    logic [D-1:0]        w_nxt_flg;
    logic [CNT_W-1:0]    w_nxt_count;
    logic [CNT_W-1:0]    w_nxt_real_cnt;
    logic [ZR_W-1:0]     w_nxt_zero_run;
    logic                w_nxt_start_pend;
    logic                w_nxt_flush_pend;
    logic                w_nxt_padded;
    logic [15:0]         w_nxt_epb_cnt;
    logic                w_nxt_in_ready;
    logic                w_nxt_out_valid;
    logic                w_nxt_out_last;

    logic                w_acc;
    logic                w_take;
    logic                w_keep;
    logic                w_flag;
    logic                w_epb_inc;
    logic [ZR_W-1:0]     w_zero_run;
    logic                w_start_pend;

    assign w_acc  = in_valid && r_in_ready;
    assign w_take = r_out_valid && out_ready;

    gg_nal_byte_filter #(
        .EPB_STRIP (EPB_STRIP)
    ) u_filter (
        .i_byte         (in_byte),
        .i_zero_run     (r_zero_run),
        .i_start_pend   (r_start_pend),
        .o_keep_c       (w_keep),
        .o_flag_c       (w_flag),
        .o_epb_inc_c    (w_epb_inc),
        .o_zero_run_c   (w_zero_run),
        .o_start_pend_c (w_start_pend)
    );

    // Next-state, buffer update and next value of every registered output
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_buf        = r_buf;
        w_nxt_flg        = r_flg;
        w_nxt_count      = r_count;
        w_nxt_real_cnt   = r_real_cnt;
        w_nxt_zero_run   = r_zero_run;
        w_nxt_start_pend = r_start_pend;
        w_nxt_flush_pend = r_flush_pend;
        w_nxt_padded     = r_padded;
        w_nxt_epb_cnt    = r_epb_cnt;

        case (r_state)
            FILL: begin
                if (w_acc) begin
                    w_nxt_zero_run   = w_zero_run;
                    w_nxt_start_pend = w_start_pend;
                    if (w_epb_inc && (r_epb_cnt != 16'hFFFF)) begin
                        w_nxt_epb_cnt = r_epb_cnt + 16'd1;
                    end
                    if (w_keep) begin
                        for (int k = 0; k < D; k++) begin
                            if (CNT_W'(k) == r_count) begin
                                w_nxt_buf[(D-1-k)*8 +: 8] = in_byte;
                                w_nxt_flg[D-1-k]          = w_flag;
                            end
                        end
                        w_nxt_count = r_count + CNT_W'(1);
                    end
                    if (in_last) begin
                        w_nxt_flush_pend = 1'b1;
                    end
                    if (w_nxt_count == CNT_W'(D)) begin
                        w_nxt_state = FULL;
                    end else if (in_last) begin
                        w_nxt_state = FLUSH;
                    end
                end
            end

            FULL: begin
                if (w_take) begin
                    w_nxt_buf   = r_buf << WID;
                    w_nxt_flg   = r_flg << BYTE_WID;
                    w_nxt_count = CNT_W'(PAD_BYTES);
                    w_nxt_state = r_flush_pend ? FLUSH : FILL;
                end
            end

            FLUSH: begin
                if (!r_padded) begin
                    // zero filler past the real bytes; zero_run deliberately untouched
                    for (int k = 0; k < D; k++) begin
                        if (CNT_W'(k) >= r_count) begin
                            w_nxt_buf[(D-1-k)*8 +: 8] = ZERO_BYTE;
                            w_nxt_flg[D-1-k]          = 1'b0;
                        end
                    end
                    w_nxt_real_cnt = r_count;
                    w_nxt_count    = CNT_W'(D);
                    w_nxt_padded   = 1'b1;
                end else if (w_take) begin
                    if (r_real_cnt <= CNT_W'(BYTE_WID)) begin
                        w_nxt_buf        = '0;
                        w_nxt_flg        = '0;
                        w_nxt_count      = '0;
                        w_nxt_real_cnt   = '0;
                        w_nxt_zero_run   = '0;
                        w_nxt_start_pend = 1'b0;
                        w_nxt_flush_pend = 1'b0;
                        w_nxt_padded     = 1'b0;
                        w_nxt_state      = FILL;
                    end else begin
                        w_nxt_buf      = r_buf << WID;
                        w_nxt_flg      = r_flg << BYTE_WID;
                        w_nxt_count    = r_count - CNT_W'(BYTE_WID);
                        w_nxt_real_cnt = r_real_cnt - CNT_W'(BYTE_WID);
                    end
                end
            end

            default: begin
                w_nxt_state = FILL;
            end
        endcase

        w_nxt_in_ready  = (w_nxt_state == FILL) && (w_nxt_count < CNT_W'(D));
        w_nxt_out_valid = (w_nxt_state == FULL) || ((w_nxt_state == FLUSH) && w_nxt_padded);
        w_nxt_out_last  = (w_nxt_state == FLUSH) && w_nxt_padded
                          && (w_nxt_real_cnt <= CNT_W'(BYTE_WID));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= FILL;
            r_buf        <= '0;
            r_flg        <= '0;
            r_count      <= '0;
            r_real_cnt   <= '0;
            r_zero_run   <= '0;
            r_start_pend <= 1'b0;
            r_flush_pend <= 1'b0;
            r_padded     <= 1'b0;
            r_epb_cnt    <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_buf        <= w_nxt_buf;
            r_flg        <= w_nxt_flg;
            r_count      <= w_nxt_count;
            r_real_cnt   <= w_nxt_real_cnt;
            r_zero_run   <= w_nxt_zero_run;
            r_start_pend <= w_nxt_start_pend;
            r_flush_pend <= w_nxt_flush_pend;
            r_padded     <= w_nxt_padded;
            r_epb_cnt    <= w_nxt_epb_cnt;
            r_in_ready   <= w_nxt_in_ready;
            r_out_valid  <= w_nxt_out_valid;
            r_out_last   <= w_nxt_out_last;
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_last      = r_out_last;
    assign out_bits      = r_buf[D*8-1 -: WID];
    assign out_pad       = r_buf[PAD_WID-1:0];
    assign out_nal_start = r_flg[D-1 -: BYTE_WID];
    assign epb_cnt       = r_epb_cnt;

endmodule

// File: tb/tb_gg_nal_word_packer.sv
// Directed scoreboard bench for gg_nal_word_packer: one instance strips EPBs, a
// second keeps them; expected words come from a queue-based reference model.
module tb_gg_nal_word_packer;

    localparam int unsigned WID       = 128;
    localparam int unsigned PAD_WID   = 32;
    localparam int unsigned BYTE_WID  = WID / 8;
    localparam int unsigned PAD_BYTES = PAD_WID / 8;
    localparam int          BUDGET    = 400;

    typedef struct {
        logic [WID-1:0]      bits;
        logic [PAD_WID-1:0]  pad;
        logic [BYTE_WID-1:0] nal;
        logic                last;
    } exp_t;

    logic clk;
    logic rst;
    logic sel;
    logic drv_vld;
    logic drv_last;
    logic [7:0] drv_byte;
    logic ordy;

    logic                a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [WID-1:0]      a_out_bits;
    logic [PAD_WID-1:0]  a_out_pad;
    logic [BYTE_WID-1:0] a_out_nal;
    logic [15:0]         a_epb;
    logic                b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [WID-1:0]      b_out_bits;
    logic [PAD_WID-1:0]  b_out_pad;
    logic [BYTE_WID-1:0] b_out_nal;
    logic [15:0]         b_epb;

    logic                w_in_ready, w_out_valid, w_out_last;
    logic [WID-1:0]      w_out_bits;
    logic [PAD_WID-1:0]  w_out_pad;
    logic [BYTE_WID-1:0] w_out_nal;
    logic [15:0]         w_epb;

    int n_checks;
    int n_fail;
    logic [7:0] q_raw[$];
    exp_t q_exp[$];
    logic [WID-1:0]      first_bits;
    logic [BYTE_WID-1:0] first_nal;

    assign a_in_valid  = drv_vld && !sel;
    assign b_in_valid  = drv_vld && sel;
    assign a_out_ready = ordy && !sel;
    assign b_out_ready = ordy && sel;

    assign w_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign w_out_valid = sel ? b_out_valid : a_out_valid;
    assign w_out_last  = sel ? b_out_last  : a_out_last;
    assign w_out_bits  = sel ? b_out_bits  : a_out_bits;
    assign w_out_pad   = sel ? b_out_pad   : a_out_pad;
    assign w_out_nal   = sel ? b_out_nal   : a_out_nal;
    assign w_epb       = sel ? b_epb       : a_epb;

    gg_nal_word_packer #(.WID(WID), .PAD_WID(PAD_WID), .EPB_STRIP(1'b1)) u_dut (
        .clk(clk), .reset(rst), .in_byte(drv_byte), .in_valid(a_in_valid),
        .in_last(drv_last), .in_ready(a_in_ready), .out_bits(a_out_bits),
        .out_pad(a_out_pad), .out_nal_start(a_out_nal), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last), .epb_cnt(a_epb)
    );

    gg_nal_word_packer #(.WID(WID), .PAD_WID(PAD_WID), .EPB_STRIP(1'b0)) u_dut_keep (
        .clk(clk), .reset(rst), .in_byte(drv_byte), .in_valid(b_in_valid),
        .in_last(drv_last), .in_ready(b_in_ready), .out_bits(b_out_bits),
        .out_pad(b_out_pad), .out_nal_start(b_out_nal), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .epb_cnt(b_epb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: filter q_raw into clean bytes + header flags, then cut words
    task automatic build_exp(input bit strip);
        logic [7:0] clean[$];
        bit         fl[$];
        int         zr;
        bit         pend;
        int         n;
        exp_t       e;
        zr   = 0;
        pend = 1'b0;
        foreach (q_raw[i]) begin
            if (strip && zr >= 2 && q_raw[i] == 8'h03) begin
                zr = 0;
            end else begin
                clean.push_back(q_raw[i]);
                fl.push_back(pend);
                pend = (q_raw[i] == 8'h01) && (zr >= 2);
                zr   = (q_raw[i] == 8'h00) ? ((zr < 3) ? zr + 1 : 3) : 0;
            end
        end
        n = clean.size();
        for (int p = 0; ; p += BYTE_WID) begin
            e.bits = '0;
            e.pad  = '0;
            e.nal  = '0;
            for (int j = 0; j < BYTE_WID; j++) begin
                if (p + j < n) begin
                    e.bits[WID-1-8*j -: 8] = clean[p+j];
                    e.nal[BYTE_WID-1-j]    = fl[p+j];
                end
            end
            for (int j = 0; j < PAD_BYTES; j++) begin
                if (p + BYTE_WID + j < n) e.pad[PAD_WID-1-8*j -: 8] = clean[p+BYTE_WID+j];
            end
            e.last = (n - p <= BYTE_WID);
            q_exp.push_back(e);
            if (e.last) break;
        end
    endtask

    task automatic drive_stream(input bit with_last);
        int guard;
        foreach (q_raw[i]) begin
            drv_vld  = 1'b1;
            drv_byte = q_raw[i];
            drv_last = with_last && (i == q_raw.size() - 1);
            guard    = 0;
            while (!w_in_ready && guard < BUDGET) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= BUDGET) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout observed=0 expected=1");
                break;
            end
            @(negedge clk);
        end
        drv_vld  = 1'b0;
        drv_last = 1'b0;
    endtask

    task automatic consume(input int stall);
        int   n;
        int   guard;
        exp_t e;
        n = q_exp.size();
        for (int w = 0; w < n; w++) begin
            guard = 0;
            while (!w_out_valid && guard < BUDGET) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= BUDGET) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_valid_timeout observed=0 expected=1 word=%0d", w);
                return;
            end
            e = q_exp[0];
            if (w == 0 && stall > 0) begin
                for (int c = 0; c < stall; c++) begin
                    chk("stall_bits", w_out_bits, e.bits);
                    chk("stall_pad", WID'(w_out_pad), WID'(e.pad));
                    chk("stall_in_ready", WID'(w_in_ready), WID'(1'b0));
                    chk("stall_valid", WID'(w_out_valid), WID'(1'b1));
                    @(negedge clk);
                end
                ordy = 1'b1;
            end
            chk("word_bits", w_out_bits, e.bits);
            chk("word_pad", WID'(w_out_pad), WID'(e.pad));
            chk("word_nal", WID'(w_out_nal), WID'(e.nal));
            chk("word_last", WID'(w_out_last), WID'(e.last));
            if (w == 0) begin
                first_bits = w_out_bits;
                first_nal  = w_out_nal;
            end
            void'(q_exp.pop_front());
            @(negedge clk);
            if (w == 0 && stall > 0) chk("stall_accept", WID'(w_out_valid), WID'(1'b0));
        end
    endtask

    task automatic run(input int stall);
        fork
            drive_stream(1'b1);
            consume(stall);
        join
        repeat (3) @(negedge clk);
        chk("idle_valid", WID'(w_out_valid), WID'(1'b0));
    endtask

    task automatic load_case1();
        q_raw = {};
        for (int i = 0; i < 36; i++) q_raw.push_back(8'(8'h10 + i));
    endtask

    task automatic load_epb_case();
        q_raw = {8'h00, 8'h00, 8'h03, 8'h01, 8'h65};
        for (int i = 0; i < 11; i++) q_raw.push_back(8'(8'h70 + i));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        sel      = 1'b0;
        drv_vld  = 1'b0;
        drv_last = 1'b0;
        drv_byte = 8'h00;
        ordy     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", WID'(w_out_valid), WID'(1'b0));
        chk("rst_last", WID'(w_out_last), WID'(1'b0));
        chk("rst_in_ready", WID'(w_in_ready), WID'(1'b0));
        chk("rst_bits", w_out_bits, '0);
        chk("rst_epb", WID'(w_epb), '0);
        rst = 1'b1;
        @(negedge clk);

        // plain payload, three words, last on the flush word
        load_case1();
        build_exp(1'b1);
        run(0);
        chk("t1_first_bits", first_bits, 128'h101112131415161718191a1b1c1d1e1f);

        // start code: header byte flagged after 00 00 00 01
        q_raw = {8'h00, 8'h00, 8'h00, 8'h01, 8'h27, 8'h42, 8'he0, 8'h2a};
        for (int i = 0; i < 16; i++) q_raw.push_back(8'(8'h40 + i));
        build_exp(1'b1);
        run(0);
        chk("t2_prefix", WID'(first_bits[WID-1 -: 40]), WID'(40'h0000000127));
        chk("t2_nal", WID'(first_nal), WID'(16'h0800));

        // EPB stripped; the following 0x01 must not start a NAL
        load_epb_case();
        build_exp(1'b1);
        run(0);
        chk("t3_prefix", WID'(first_bits[WID-1 -: 32]), WID'(32'h00000165));
        chk("t3_nal", WID'(first_nal), '0);
        chk("t3_epb", WID'(w_epb), WID'(16'd1));

        // same stream through the non-stripping instance
        sel = 1'b1;
        @(negedge clk);
        load_epb_case();
        build_exp(1'b0);
        run(0);
        chk("t4_prefix", WID'(first_bits[WID-1 -: 40]), WID'(40'h0000030165));
        chk("t4_epb", WID'(w_epb), '0);
        sel = 1'b0;
        @(negedge clk);

        // back-pressure: first word held for 10 cycles
        load_case1();
        build_exp(1'b1);
        ordy = 1'b0;
        run(10);
        ordy = 1'b1;

        // reset in the middle of a word, then case 1 again
        q_raw = {};
        for (int i = 0; i < 7; i++) q_raw.push_back(8'(8'h10 + i));
        drive_stream(1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", WID'(w_out_valid), WID'(1'b0));
        chk("t6_rst_in_ready", WID'(w_in_ready), WID'(1'b0));
        chk("t6_rst_epb", WID'(w_epb), '0);
        chk("t6_rst_bits", w_out_bits, '0);
        rst = 1'b1;
        @(negedge clk);
        load_case1();
        build_exp(1'b1);
        run(0);
        chk("t6_first_bits", first_bits, 128'h101112131415161718191a1b1c1d1e1f);
        chk("t6_epb", WID'(w_epb), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gg_nal_word_packer.md
Name: gg_nal_word_packer

Overview:
- Converts a raw H.264 Annex-B byte stream into the wide word format consumed by the parse lattices: WID-bit big-endian word, PAD_WID-bit lookahead and per-byte NAL-start flags.
- Strips emulation-prevention bytes and detects start codes in hardware, so parsers see clean RBSP bits.
- Sits between the bitstream source (DMA/file feeder) and gg_parse_nal_lattice / the slice, macroblock and block lattices.

Parameters:
- WID, 128, output word width in bits; multiple of 8.
- PAD_WID, 32, lookahead width in bits; multiple of 8, less than or equal to WID.
- EPB_STRIP, 1, 1 = drop 0x03 following 00 00; 0 = pass 0x03 through.
- Derived: BYTE_WID = WID/8, PAD_BYTES = PAD_WID/8, D = BYTE_WID+PAD_BYTES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- in_byte  input  8  raw stream byte
- in_valid  input  1  in_byte valid
- in_last  input  1  qualifies final byte of stream
- in_ready  output  1  byte accepted when in_valid&in_ready
- out_bits  output  WID  byte 0 at [WID-1-:8]
- out_pad  output  PAD_WID  next PAD_BYTES bytes after out_bits
- out_nal_start  output  BYTE_WID  bit BYTE_WID-1-k set if byte k is a NAL header byte
- out_valid  output  1  word valid
- out_ready  input  1  word consumed when out_valid&out_ready
- out_last  output  1  final word of stream
- epb_cnt  output  16  count of stripped 0x03 bytes, saturating

Behaviour:
- Reset (async, low): buffer and flags cleared, count=0, zero_run=0, start_pend=0, epb_cnt=0, state FILL. Outputs: out_valid=0, out_last=0, out_bits/out_pad/out_nal_start=0, in_ready=0 while reset is low.
- Buffer: D-byte shift buffer with a 1-bit start flag per byte and fill count 0..D.
- Byte filter on each accepted byte (order: EPB check, then start check):
  - zero_run counts consecutive raw 0x00 bytes, saturating at 3.
  - EPB_STRIP=1 and zero_run>=2 and byte==0x03: byte discarded, epb_cnt++, zero_run=0.
  - byte==0x01 and zero_run>=2: start_pend=1; byte is kept.
  - Every kept byte is appended at position count. Its flag = start_pend; start_pend is then cleared, except when the byte is the 0x01 that set it.
  - zero_run is updated from kept bytes.
- FILL: in_ready=1 if count<D. When count reaches D, go to FULL. Accepting in_last sets flush_pend.
- FULL: in_ready=0, out_valid=1. out_bits = bytes 0..BYTE_WID-1, out_pad = next PAD_BYTES bytes, out_nal_start = flags 0..BYTE_WID-1.
  - On handshake: shift left by BYTE_WID, count=PAD_BYTES.
  - Next state is FLUSH if flush_pend, else FILL.
  - Throughput is 1 byte/cycle with one bubble per word.
- FLUSH: in the first FLUSH cycle, bytes count..D-1 are filled with 0x00, flag 0; filler does not update zero_run; real_cnt = real bytes held. Then FULL-like output.
  - out_last=1 iff real_cnt<=BYTE_WID.
  - After out_last handshake: count=0, zero_run=0, start_pend=0, flush_pend=0, back to FILL. Otherwise shift and repeat FLUSH.
- in_last accepted with count==D-1: byte stored, go to FULL with flush_pend=1.
- out_ready low: out_* held stable, no input accepted.
- in_last on a stripped 0x03: flush still triggered.
- Reset mid-word: partial word lost, no output emitted.

Decomposition:
- Package gg_nal_pkg: start-code and EPB constants (8'h00, 8'h01, 8'h03), zero_run saturation value, state enum {FILL, FULL, FLUSH}.
- Sub-module gg_nal_byte_filter: per-byte EPB strip and start detect. Outputs keep, flag and epb_inc, so the filter is unit-testable separately from the buffer.

Test Plan:
1. Bytes 0x10..0x33 (36 bytes), in_last on 0x33 -> word0: out_bits=101112..1f, out_pad=20212223, last=0. Word1: out_bits=2021..2f, out_pad=30313233, last=0. Word2: 30313233 then zeros, last=1. out_nal_start=0 throughout.
2. 00 00 00 01 27 42 e0 2a ... -> word0 out_nal_start=16'h0800 (byte 4 = 0x27), bits[WID-1-:40]=0000000127.
3. 00 00 03 01 65 ... with EPB_STRIP=1 -> bytes 00 00 01 65 emitted, epb_cnt=1, out_nal_start=0 (0x01 follows the strip).
4. Same stimulus with EPB_STRIP=0 -> 00 00 03 01 65 retained, epb_cnt=0.
5. out_ready low 10 cycles with word valid -> out_bits/out_pad stable and in_ready=0 for all 10 cycles. Word accepted on the cycle out_ready rises.
6. Reset asserted after 7 bytes, released, then case 1 -> outputs identical to case 1, epb_cnt=0.
